// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single-beat external memory bus between the IF and MEM stages
// Ports:
//   clk, rst   system clock; asynchronous active-low reset
//   i_req, i_addr                    IF read request in; i_rdata, i_ack, i_stall out
//   d_req, d_we, d_addr, d_sel, d_wdata  MEM request in; d_rdata, d_ack, d_stall out
//   flush      pipeline flush, cancels delivery of an in-flight IF read
//   bus_err    pulses together with the ack of a transaction that timed out
//   mem_ce, mem_we, mem_addr, mem_sel, mem_wdata  bus strobe/controls out
//   mem_rdata, mem_ack                            bus read data / completion in
module mem_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    output logic          i_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [3:0]    d_sel,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          d_stall,
    output logic          bus_err,
    input  logic          flush,
    output logic          mem_ce,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_sel,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          cancel;
    logic          last_d;
    logic          pick_d;
    logic          expired;
    logic          drop_i;
    logic [DW-1:0] cap;

    // on a tie the port that did not win last time gets the bus
    assign pick_d  = d_req & (~i_req | ~last_d);
    assign expired = ~mem_ack & (cnt == CW'(TIMEOUT - 1));
    // writes and aborted transactions return zero
    assign cap     = (mem_ack & ~mem_we) ? mem_rdata : '0;
    // a flush on the completing edge counts as well as an earlier one
    assign drop_i  = cancel | flush;
    assign i_stall = i_req & ~i_ack;
    assign d_stall = d_req & ~d_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cancel    <= 1'b0;
            last_d    <= 1'b0;
            mem_ce    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_sel   <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req | d_req) begin
                        state     <= pick_d ? BUSY_D : BUSY_I;
                        last_d    <= pick_d;
                        cnt       <= '0;
                        cancel    <= 1'b0;
                        mem_ce    <= 1'b1;
                        mem_we    <= pick_d & d_we;
                        mem_addr  <= pick_d ? d_addr : i_addr;
                        mem_sel   <= pick_d ? d_sel : 4'hF;
                        mem_wdata <= pick_d ? d_wdata : '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (state == BUSY_I && flush) cancel <= 1'b1;
                    if (mem_ack | expired) begin
                        state  <= DONE;
                        mem_ce <= 1'b0;
                        if (state == BUSY_D) begin
                            d_ack   <= 1'b1;
                            d_rdata <= cap;
                            bus_err <= expired;
                        end else if (!drop_i) begin
                            i_ack   <= 1'b1;
                            i_rdata <= cap;
                            bus_err <= expired;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // DONE: the ack pulse is on the outputs; no grant this cycle
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter sharing the single external memory bus of NCUT_MiniSys between the instruction-fetch (IF) and data-access (MEM) stages. It grants one requester at a time, sequences a single-beat transaction with a wait-state handshake and a timeout, returns registered read data, and drives per-port stall requests into the pipeline controller. It sits between the CPU core and the memory/peripheral bus.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, max cycles of mem_ce without mem_ack before abort (≥2)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- i_req  in  1  IF read request, held until i_ack or flush
- i_addr  in  AW  IF address
- i_rdata  out  DW  IF read data, valid with i_ack
- i_ack  out  1  one-cycle completion pulse to IF
- i_stall  out  1  i_req & ~i_ack
- d_req  in  1  MEM request, held until d_ack
- d_we  in  1  1 = write
- d_addr  in  AW  data address
- d_sel  in  4  byte enables
- d_wdata  in  DW  write data
- d_rdata  out  DW  read data, valid with d_ack (0 for writes)
- d_ack  out  1  one-cycle completion pulse to MEM
- d_stall  out  1  d_req & ~d_ack
- bus_err  out  1  one-cycle pulse with the ack of a timed-out transaction
- flush  in  1  pipeline flush; cancels IF delivery
- mem_ce, mem_we  out  1  bus strobe / write
- mem_addr  out  AW; mem_sel  out  4; mem_wdata  out  DW
- mem_rdata  in  DW; mem_ack  in  1  bus completion

## Operation
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE: if only one request, grant it; if both, grant the port not granted last (last_grant reg, reset = I, so first tie goes to D). Grant latches address/we/sel/wdata into mem_* regs, mem_ce=1; IF grants force mem_we=0, mem_sel=4'hF, mem_wdata=0.
- BUSY_x: hold all mem_* stable. On mem_ack=1: capture mem_rdata (0 if write), mem_ce=0, → DONE. Timeout counter cleared on grant, +1 per BUSY cycle; if it reaches TIMEOUT-1 with mem_ack=0: mem_ce=0, rdata=0, set err, → DONE.
- DONE: pulse owner's ack (and bus_err if err) for exactly one cycle, → IDLE. No grant evaluated in DONE, so a requester's stale request in its ack cycle is never re-granted.
- flush: sampled high at any edge while owner=I in BUSY_I or in the edge entering DONE sets cancel; in DONE with cancel, i_ack and bus_err stay 0; bus transaction still completes normally. flush never affects D transactions. A flush in IDLE has no effect; a pending i_req still competes.
- i_rdata/d_rdata hold last captured value between acks.
- Reset (async, rst=0): state IDLE; all outputs 0 (mem_ce, mem_we, mem_addr, mem_sel, mem_wdata, acks, rdata, bus_err); counter, err, cancel cleared; last_grant=I. Reset mid-transaction aborts it immediately with no ack.

## Timing
- Request sampled at edge N → mem_ce high from N; mem_ack sampled at edge N+k (k≥1) → owner ack high cycle after edge N+k; back in IDLE at edge N+k+1; next grant earliest at edge N+k+2.
- Zero-wait memory: 3 cycles per transaction, 2-cycle request-to-ack latency.
- Timeout: ack with bus_err after exactly TIMEOUT cycles of mem_ce.
- i_stall/d_stall combinational from inputs and registered acks only; no combinational path from mem_* inputs to any output.

## Test plan
- Zero-wait IF read, addr 0x0000_0040, mem_rdata 0x2401_0005 -> mem_ce one cycle, i_ack at cycle 2, i_rdata 0x2401_0005, i_stall low same cycle.
- D write addr 0x100, sel 4'b0011, wdata 0xDEAD_BEEF, 3 wait states -> mem_we=1, mem_sel=0011 held 4 cycles, d_ack one pulse, d_rdata 0.
- i_req and d_req continuously high, zero-wait -> grants alternate D,I,D,I starting with D, one transaction every 3 cycles.
- mem_ack never asserted, TIMEOUT=16 -> mem_ce high exactly 16 cycles, then owner ack + bus_err together for one cycle, rdata 0.
- flush pulsed during BUSY_I -> bus completes, i_ack and bus_err stay 0; following D request served normally.
- rst low during BUSY_D -> all outputs 0 immediately; after release, same d_req re-granted and completes with single d_ack.
